// File: rtl/audio_pkg.sv
// audio_pkg: shared sample types, receiver state encoding and helpers for
// the audio filter chain.
package audio_pkg;

   // Sample width used by the stereo types below; blocks that take a
   // DATA_WIDTH parameter must keep it equal to this value.
   localparam int DATA_WIDTH_DEFAULT = 24;

   typedef logic signed [DATA_WIDTH_DEFAULT-1:0] sample_t;

   typedef struct packed {
      sample_t left;
      sample_t right;
   } stereo_t;

   typedef enum logic [1:0] {
      ALIGN,
      LEFT,
      RIGHT
   } rx_state_t;

   // Move the nbits received bits (sitting in the LSBs) up to the MSBs so a
   // short slot reads as a left-justified, zero-padded word.
   function automatic sample_t left_justify(sample_t word, int nbits);
      if (nbits >= DATA_WIDTH_DEFAULT) begin
         return word;
      end
      return word << (DATA_WIDTH_DEFAULT - nbits);
   endfunction

endpackage

// File: rtl/i2s_adc_receiver_if.sv
// i2s_adc_receiver_if: read-side bus between the I2S receiver and the
// filter stage that drains its stereo FIFO.
interface i2s_adc_receiver_if #(
   parameter int DATA_WIDTH = audio_pkg::DATA_WIDTH_DEFAULT,
   parameter int ADDR_WIDTH = 3
);
   logic                  read;
   logic                  clear_overflow;
   logic                  read_ready;
   logic [DATA_WIDTH-1:0] readdata_left;
   logic [DATA_WIDTH-1:0] readdata_right;
   logic [ADDR_WIDTH:0]   fill_level;
   logic                  overflow;

   // Consumer side: pops pairs and clears the overflow flag.
   modport master (
      output read, clear_overflow,
      input  read_ready, readdata_left, readdata_right, fill_level, overflow
   );

   // Receiver side: presents the FIFO head and status.
   modport slave (
      input  read, clear_overflow,
      output read_ready, readdata_left, readdata_right, fill_level, overflow
   );
endinterface

// File: rtl/stereo_sample_fifo.sv
// stereo_sample_fifo: first-word fall-through FIFO of stereo pairs. A push
// into a full FIFO only succeeds when a pop happens on the same clock.
module stereo_sample_fifo
   import audio_pkg::*;
#(
   parameter int ADDR_WIDTH = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                push,
   input  stereo_t             push_data,
   input  logic                pop,
   output stereo_t             head,
   output logic                empty,
   output logic                full,
   output logic [ADDR_WIDTH:0] count
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

   stereo_t               mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == COUNT_FULL);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign count   = count_q;
   // Storage is not reset, so the head is forced to zero while empty.
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   // Advance pointers and occupancy; pointers wrap modulo DEPTH.
   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset empties the FIFO at once.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Sample storage write port.
   always_ff @(posedge clock) begin
      // NOTE: the array is deliberately not reset; occupancy decides what is valid.
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver: deserializes the codec I2S ADC stream into signed
// left/right pairs and buffers them in a stereo FIFO for the filter stage.
module i2s_adc_receiver
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
   parameter int ADDR_WIDTH  = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic aud_bclk,
   input  logic aud_adclrck,
   input  logic aud_adcdat,
   i2s_adc_receiver_if.slave bus
);
   localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 2);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH);
   localparam logic [CNT_WIDTH-1:0] CNT_SAT  = CNT_WIDTH'(DATA_WIDTH + 1);

   logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
   logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
   logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
   logic                   bclk_prev_q, bclk_prev_d;
   logic                   lrck_prev_q, lrck_prev_d;
   logic                   bclk_s, lrck_s, dat_s;
   logic                   bit_rise, lrck_fall, lrck_rise, lrck_edge;
   rx_state_t              state_q, state_d;
   sample_t                shift_q, shift_d;
   sample_t                left_q, left_d;
   sample_t                word_now;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
   logic                   latch_left, push;
   stereo_t                push_data, head;
   logic                   fifo_empty, fifo_full, drop;
   logic                   overflow_q, overflow_d;

   // Shift each asynchronous codec pin one stage deeper into its synchronizer.
   always_comb begin
      bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], aud_bclk};
      lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], aud_adclrck};
      dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], aud_adcdat};
   end

   assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
   assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
   assign dat_s  = dat_sync_q[SYNC_STAGES-1];

   // lrck is judged only by its value at successive bclk rises.
   assign bit_rise  = bclk_s & ~bclk_prev_q;
   assign lrck_fall = bit_rise & lrck_prev_q & ~lrck_s;
   assign lrck_rise = bit_rise & ~lrck_prev_q & lrck_s;
   assign lrck_edge = lrck_fall | lrck_rise;

   // Remember the previous bclk level and the lrck level at the last bclk rise.
   always_comb begin
      bclk_prev_d = bclk_s;
      lrck_prev_d = bit_rise ? lrck_s : lrck_prev_q;
   end

   // Synchronizer and edge-detect registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bclk_sync_q <= '0;
         lrck_sync_q <= '0;
         dat_sync_q  <= '0;
         bclk_prev_q <= 1'b0;
         lrck_prev_q <= 1'b0;
      end else begin
         bclk_sync_q <= bclk_sync_d;
         lrck_sync_q <= lrck_sync_d;
         dat_sync_q  <= dat_sync_d;
         bclk_prev_q <= bclk_prev_d;
         lrck_prev_q <= lrck_prev_d;
      end
   end

   // Frame state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ALIGN;
      else       state_q <= state_d;
   end

   // Next state: wait for a falling lrck so every pair opens with a left word.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ALIGN:   if (lrck_fall) state_d = LEFT;
         LEFT:    if (lrck_rise) state_d = RIGHT;
         RIGHT:   if (lrck_fall) state_d = LEFT;
         default: state_d = ALIGN;
      endcase
   end

   // Frame outputs: hold the left word at mid-frame, push the pair at frame end.
   always_comb begin
      latch_left = (state_q == LEFT) && lrck_rise;
      push       = (state_q == RIGHT) && lrck_fall;
   end

   // Bit framing: the rise that reveals an lrck edge is count 0 (the I2S
   // delay bit); counts 1..DATA_WIDTH shift in MSB first, later bits drop.
   always_comb begin
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_WIDTH'(1);
      word_now = left_justify(shift_q, int'(cnt_q));
      if (bit_rise) begin
         if (lrck_edge) begin
            shift_d = '0;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_inc;
            if (cnt_inc <= CNT_LAST) shift_d = {shift_q[DATA_WIDTH-2:0], dat_s};
         end
      end
      if (latch_left) left_d = word_now;
   end

   // Shift register, bit counter and left holding register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
         left_q  <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
      end
   end

   assign push_data = '{left: left_q, right: word_now};

   // A full FIFO only loses the pair when nothing is popped on the same clock.
   assign drop = push & fifo_full & ~bus.read;

   // Sticky overflow: a new drop beats a simultaneous clear.
   always_comb begin
      overflow_d = drop | (overflow_q & ~bus.clear_overflow);
   end

   // Overflow flag register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) overflow_q <= 1'b0;
      else       overflow_q <= overflow_d;
   end

   stereo_sample_fifo #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (bus.read),
      .head      (head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (bus.fill_level)
   );

   assign bus.read_ready     = ~fifo_empty;
   assign bus.readdata_left  = head.left;
   assign bus.readdata_right = head.right;
   assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// tb_i2s_adc_receiver: directed I2S frames with hand-computed expected pairs,
// a vector table for framing cases and sequences for FIFO/reset corners.
module tb_i2s_adc_receiver;
   localparam int SYNC_STAGES = 2;
   localparam int HALF_BCLK   = 40;  // 8 system clocks per bclk period

   logic clock       = 1'b0;
   logic reset       = 1'b1;
   logic aud_bclk    = 1'b1;
   logic aud_adclrck = 1'b1;
   logic aud_adcdat  = 1'b0;

   int checks   = 0;
   int failures = 0;
   bit parked   = 1'b0;  // the next left slot's delay bit was already sent

   typedef struct {
      logic [23:0] left;
      logic [23:0] right;
      int          nbits;      // data bits sent per slot
      int          slot_len;   // bclk periods per slot, delay bit included
      logic [23:0] exp_left;
      logic [23:0] exp_right;
   } vec_t;

   vec_t vecs [5];

   i2s_adc_receiver_if #(.DATA_WIDTH(24), .ADDR_WIDTH(3)) bus ();

   i2s_adc_receiver #(
      .DATA_WIDTH  (24),
      .ADDR_WIDTH  (3),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .aud_bclk    (aud_bclk),
      .aud_adclrck (aud_adclrck),
      .aud_adcdat  (aud_adcdat),
      .bus         (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic check_head(input string name, input logic [23:0] l, input logic [23:0] r);
      check({name, "_left"}, {8'h0, bus.readdata_left}, {8'h0, l});
      check({name, "_right"}, {8'h0, bus.readdata_right}, {8'h0, r});
   endtask

   // One bclk period: lrck/data change on the falling edge, codec-style.
   task automatic i2s_bit(input logic lr, input logic d);
      aud_bclk    = 1'b0;
      aud_adclrck = lr;
      aud_adcdat  = d;
      #HALF_BCLK;
      aud_bclk = 1'b1;
      #HALF_BCLK;
   endtask

   task automatic send_slot(input logic lr, input logic [23:0] word, input int nbits, input int slot_len);
      int first;
      first  = (parked && lr == 1'b0) ? 1 : 0;
      parked = 1'b0;
      for (int k = first; k < slot_len; k++) begin
         i2s_bit(lr, (k >= 1 && k <= nbits) ? word[nbits-k] : 1'b0);
      end
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int nbits, input int slot_len);
      send_slot(1'b0, l, nbits, slot_len);
      send_slot(1'b1, r, nbits, slot_len);
   endtask

   // Delay bit of the next left slot (this completes the pending pair), then
   // park the bus with bclk high. Optional read/clear strobes cover exactly
   // the clock on which the pair is pushed.
   task automatic close_frame(input bit pop_on_push, input bit clr_on_push, input bit chk_latency);
      aud_bclk    = 1'b0;
      aud_adclrck = 1'b0;
      aud_adcdat  = 1'b0;
      #HALF_BCLK;
      aud_bclk = 1'b1;
      #(10 * SYNC_STAGES);
      if (chk_latency) check("ready_not_early", 32'(bus.read_ready), 32'd0);
      bus.read           = pop_on_push;
      bus.clear_overflow = clr_on_push;
      #10;
      bus.read           = 1'b0;
      bus.clear_overflow = 1'b0;
      #(HALF_BCLK - 10 * SYNC_STAGES - 10);
      if (chk_latency) check("ready_by_sync_plus_2", 32'(bus.read_ready), 32'd1);
      parked = 1'b1;
   endtask

   task automatic pop_pair();
      @(negedge clock) bus.read = 1'b1;
      @(negedge clock) bus.read = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clock) bus.clear_overflow = 1'b1;
      @(negedge clock) bus.clear_overflow = 1'b0;
   endtask

   function automatic logic [23:0] frame_left(input int i);
      return 24'hC00000 + 24'(i * 17);
   endfunction

   function automatic logic [23:0] frame_right(input int i);
      return 24'h300000 + 24'(i);
   endfunction

   initial begin
      vecs[0] = '{24'h123456, 24'hFEDCBA, 24, 32, 24'h123456, 24'hFEDCBA};
      vecs[1] = '{24'h00A5A5, 24'h005A5A, 16, 17, 24'hA5A500, 24'h5A5A00};
      // 24-bclk slot: the LSB would land on the next slot's ignored delay bit.
      vecs[2] = '{24'h800001, 24'h7FFFFF, 24, 24, 24'h800000, 24'h7FFFFE};
      vecs[3] = '{24'hABCDEF, 24'h012345, 24, 25, 24'hABCDEF, 24'h012345};
      vecs[4] = '{24'h000081, 24'h00007E,  8, 12, 24'h810000, 24'h7E0000};

      bus.read           = 1'b0;
      bus.clear_overflow = 1'b0;

      // Reset state.
      repeat (3) @(negedge clock);
      check("rst_ready", 32'(bus.read_ready), 32'd0);
      check("rst_fill", 32'(bus.fill_level), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      check_head("rst_data", 24'h0, 24'h0);
      reset = 1'b0;

      // Table-driven frames; a few right-slot bits first so the first left
      // slot opens with a falling lrck edge.
      send_slot(1'b1, 24'h0, 0, 4);
      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].left, vecs[i].right, vecs[i].nbits, vecs[i].slot_len);
         close_frame(1'b0, 1'b0, i == 0);
         check($sformatf("vec%0d_fill", i), 32'(bus.fill_level), 32'd1);
         check_head($sformatf("vec%0d", i), vecs[i].exp_left, vecs[i].exp_right);
         pop_pair();
         check($sformatf("vec%0d_fill_after_pop", i), 32'(bus.fill_level), 32'd0);
      end
      pop_pair();
      check("empty_read_fill", 32'(bus.fill_level), 32'd0);
      check("empty_read_ready", 32'(bus.read_ready), 32'd0);

      // Stream starting mid-right-slot: nothing until a full pair follows
      // the first falling lrck edge.
      @(negedge clock) reset = 1'b1;
      @(negedge clock) reset = 1'b0;
      parked = 1'b0;
      for (int k = 0; k < 10; k++) i2s_bit(1'b1, 1'b1);
      send_frame(24'h111111, 24'h222222, 24, 25);
      check("midslot_no_push", 32'(bus.fill_level), 32'd0);
      send_frame(24'h333333, 24'h444444, 24, 25);
      close_frame(1'b0, 1'b0, 1'b0);
      check("midslot_fill", 32'(bus.fill_level), 32'd2);
      check_head("midslot_first", 24'h111111, 24'h222222);
      pop_pair();
      check_head("midslot_second", 24'h333333, 24'h444444);
      pop_pair();

      // Nine frames, no reads: the ninth is dropped and overflow sticks.
      for (int i = 1; i <= 9; i++) send_frame(frame_left(i), frame_right(i), 24, 25);
      close_frame(1'b0, 1'b0, 1'b0);
      check("ovf_fill", 32'(bus.fill_level), 32'd8);
      check("ovf_flag", 32'(bus.overflow), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         check_head($sformatf("ovf_order%0d", i), frame_left(i), frame_right(i));
         pop_pair();
      end
      check("ovf_drained", 32'(bus.read_ready), 32'd0);
      check("ovf_sticky", 32'(bus.overflow), 32'd1);
      pulse_clear();
      check("ovf_cleared", 32'(bus.overflow), 32'd0);

      // Drop and clear on the same clock: the drop wins.
      for (int i = 10; i <= 18; i++) send_frame(frame_left(i), frame_right(i), 24, 25);
      close_frame(1'b0, 1'b1, 1'b0);
      check("setwins_flag", 32'(bus.overflow), 32'd1);
      check("setwins_fill", 32'(bus.fill_level), 32'd8);
      pulse_clear();
      check("setwins_cleared", 32'(bus.overflow), 32'd0);

      // Full FIFO, read on the push clock: both happen, no overflow.
      check_head("fullrw_head_before", frame_left(10), frame_right(10));
      send_frame(frame_left(19), frame_right(19), 24, 25);
      close_frame(1'b1, 1'b0, 1'b0);
      check("fullrw_fill", 32'(bus.fill_level), 32'd8);
      check("fullrw_overflow", 32'(bus.overflow), 32'd0);
      check_head("fullrw_head_after", frame_left(11), frame_right(11));
      for (int i = 11; i <= 17; i++) pop_pair();
      check_head("fullrw_tail", frame_left(19), frame_right(19));
      pop_pair();
      check("fullrw_empty", 32'(bus.fill_level), 32'd0);

      // Reset in the middle of a left word with three pairs stored.
      for (int i = 20; i <= 22; i++) send_frame(frame_left(i), frame_right(i), 24, 25);
      close_frame(1'b0, 1'b0, 1'b0);
      check("rstmid_fill_before", 32'(bus.fill_level), 32'd3);
      parked = 1'b0;
      for (int k = 1; k <= 10; k++) i2s_bit(1'b0, k[0]);
      #3 reset = 1'b1;
      #1;
      check("rstmid_fill", 32'(bus.fill_level), 32'd0);
      check("rstmid_ready", 32'(bus.read_ready), 32'd0);
      #6 reset = 1'b0;
      send_slot(1'b1, 24'hDEAD01, 24, 25);
      send_frame(24'h0BEEF0, 24'hF00D42, 24, 25);
      check("rstmid_no_partial", 32'(bus.fill_level), 32'd0);
      close_frame(1'b0, 1'b0, 1'b0);
      check("rstmid_fill_after", 32'(bus.fill_level), 32'd1);
      check_head("rstmid_first", 24'h0BEEF0, 24'hF00D42);
      pop_pair();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
